init_command_sequencer: RTL and testbench

INIT_COMMAND_SEQUENCER -- requirements
Module: init_command_sequencer

---
 rtl/pic_pkg.sv | 39 +++
 rtl/write_strobe_capture.sv | 45 ++++
 rtl/init_command_sequencer.sv | 172 +++++++++++++++++
 tb/tb_init_command_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt-controller initialisation sequencer:
// sequencer state encoding, command-word bit positions and pulse indices.
package pic_pkg;

   typedef enum logic [2:0] {
      WAIT_ICW1 = 3'd0,
      WAIT_ICW2 = 3'd1,
      WAIT_ICW3 = 3'd2,
      WAIT_ICW4 = 3'd3,
      READY     = 3'd4
   } init_state_t;

   // ICW1 fields (A0 = 0, D4 = 1 identifies ICW1)
   localparam int ICW1_IC4_BIT    = 0;
   localparam int ICW1_SNGL_BIT   = 1;
   localparam int ICW1_LTIM_BIT   = 3;
   localparam int ICW1_SELECT_BIT = 4;

   // ICW2 interrupt vector base field
   localparam int VECTOR_MSB = 7;
   localparam int VECTOR_LSB = 3;

   // ICW4 fields
   localparam int ICW4_UPM_BIT  = 0;
   localparam int ICW4_AEOI_BIT = 1;
   localparam int ICW4_MS_BIT   = 2;
   localparam int ICW4_BUF_BIT  = 3;

   // With A0 = 0 and D4 = 0, D3 distinguishes OCW3 (1) from OCW2 (0)
   localparam int OCW3_SELECT_BIT = 3;

   // Positions of the command pulses inside the internal pulse vector
   localparam int PULSE_ICW1   = 4;
   localparam int PULSE_ICW2_4 = 3;
   localparam int PULSE_OCW1   = 2;
   localparam int PULSE_OCW2   = 1;
   localparam int PULSE_OCW3   = 0;

endpackage

// File: rtl/write_strobe_capture.sv
// Captures CPU writes: registers address/data on every qualified cycle and
// flags one command event on the first cycle after the strobe ends.
module write_strobe_capture (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       chip_select_n,
   input  logic       write_enable_n,
   input  logic       address,
   input  logic [7:0] internal_data_bus,
   output logic       command_event,
   output logic       captured_address,
   output logic [7:0] captured_data
);

   logic strobe_low;
   logic qualified;
   logic write_active;
   logic discard_pending;

   // A strobe already low when reset hits is suppressed until it goes away,
   // so a write cut in half by reset never produces an event.
   assign strobe_low    = ~chip_select_n & ~write_enable_n;
   assign qualified     = strobe_low & ~discard_pending;
   assign command_event = write_active & ~qualified;

   // Track the qualified write and latch its address/data every cycle it lasts
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         write_active     <= 1'b0;
         discard_pending  <= 1'b1;
         captured_address <= 1'b0;
         captured_data    <= 8'h00;
      end else begin
         write_active <= qualified;
         if (!strobe_low) begin
            discard_pending <= 1'b0;
         end
         if (qualified) begin
            captured_address <= address;
            captured_data    <= internal_data_bus;
         end
      end
   end

endmodule

// File: rtl/init_command_sequencer.sv
// Walks the ICW1..ICW4 initialisation sequence, holds the resulting
// configuration and emits one-cycle command pulses toward Control_Logic.
module init_command_sequencer
   import pic_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       chip_select_n,
   input  logic       write_enable_n,
   input  logic       address,
   input  logic [7:0] internal_data_bus,
   output logic       ICW_1,
   output logic       ICW_2_4,
   output logic       OCW_1,
   output logic       OCW_2,
   output logic       OCW_3,
   output logic [7:0] write_data,
   output logic       level_or_edge_toriggered_config,
   output logic       single_or_cascade_config,
   output logic       set_icw4_config,
   output logic       mode,
   output logic       auto_eoi_config,
   output logic       buffered_master_or_slave_config,
   output logic       buffered_mode_config,
   output logic [4:0] vector_base,
   output logic [7:0] cascade_device_config,
   output logic       init_done
);

   logic        command_event;
   logic        captured_address;
   logic [7:0]  captured_data;

   init_state_t state;
   init_state_t state_next;
   logic [4:0]  pulse;
   logic [4:0]  pulse_next;
   logic [7:0]  write_data_next;
   logic        level_next;
   logic        single_next;
   logic        set_icw4_next;
   logic        mode_next;
   logic        aeoi_next;
   logic        ms_next;
   logic        buf_next;
   logic [4:0]  vector_next;
   logic [7:0]  cascade_next;

   write_strobe_capture u_capture (
      .clk               (clk),
      .reset_n           (reset_n),
      .chip_select_n     (chip_select_n),
      .write_enable_n    (write_enable_n),
      .address           (address),
      .internal_data_bus (internal_data_bus),
      .command_event     (command_event),
      .captured_address  (captured_address),
      .captured_data     (captured_data)
   );

   assign ICW_1     = pulse[PULSE_ICW1];
   assign ICW_2_4   = pulse[PULSE_ICW2_4];
   assign OCW_1     = pulse[PULSE_OCW1];
   assign OCW_2     = pulse[PULSE_OCW2];
   assign OCW_3     = pulse[PULSE_OCW3];
   assign init_done = (state == READY);

   // Decode the captured command against the current state; ICW1 always wins
   always_comb begin
      state_next      = state;
      pulse_next      = 5'b00000;
      write_data_next = write_data;
      level_next      = level_or_edge_toriggered_config;
      single_next     = single_or_cascade_config;
      set_icw4_next   = set_icw4_config;
      mode_next       = mode;
      aeoi_next       = auto_eoi_config;
      ms_next         = buffered_master_or_slave_config;
      buf_next        = buffered_mode_config;
      vector_next     = vector_base;
      cascade_next    = cascade_device_config;

      if (command_event) begin
         if (!captured_address && captured_data[ICW1_SELECT_BIT]) begin
            pulse_next[PULSE_ICW1] = 1'b1;
            level_next    = captured_data[ICW1_LTIM_BIT];
            single_next   = captured_data[ICW1_SNGL_BIT];
            set_icw4_next = captured_data[ICW1_IC4_BIT];
            cascade_next  = 8'h00;
            mode_next     = 1'b0;
            aeoi_next     = 1'b0;
            ms_next       = 1'b0;
            buf_next      = 1'b0;
            state_next    = WAIT_ICW2;
         end else if (captured_address) begin
            case (state)
               WAIT_ICW2: begin
                  pulse_next[PULSE_ICW2_4] = 1'b1;
                  vector_next = captured_data[VECTOR_MSB:VECTOR_LSB];
                  if (!single_or_cascade_config) begin
                     state_next = WAIT_ICW3;
                  end else if (set_icw4_config) begin
                     state_next = WAIT_ICW4;
                  end else begin
                     state_next = READY;
                  end
               end
               WAIT_ICW3: begin
                  pulse_next[PULSE_ICW2_4] = 1'b1;
                  cascade_next = captured_data;
                  state_next   = set_icw4_config ? WAIT_ICW4 : READY;
               end
               WAIT_ICW4: begin
                  pulse_next[PULSE_ICW2_4] = 1'b1;
                  mode_next  = captured_data[ICW4_UPM_BIT];
                  aeoi_next  = captured_data[ICW4_AEOI_BIT];
                  ms_next    = captured_data[ICW4_MS_BIT];
                  buf_next   = captured_data[ICW4_BUF_BIT];
                  state_next = READY;
               end
               READY: begin
                  pulse_next[PULSE_OCW1] = 1'b1;
               end
               default: begin
               end
            endcase
         end else if (state == READY) begin
            if (captured_data[OCW3_SELECT_BIT]) begin
               pulse_next[PULSE_OCW3] = 1'b1;
            end else begin
               pulse_next[PULSE_OCW2] = 1'b1;
            end
         end
      end

      if (pulse_next != 5'b00000) begin
         write_data_next = captured_data;
      end
   end

   // Register state, pulses, latched data and configuration together
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state                           <= WAIT_ICW1;
         pulse                           <= 5'b00000;
         write_data                      <= 8'h00;
         level_or_edge_toriggered_config <= 1'b0;
         single_or_cascade_config        <= 1'b0;
         set_icw4_config                 <= 1'b0;
         mode                            <= 1'b0;
         auto_eoi_config                 <= 1'b0;
         buffered_master_or_slave_config <= 1'b0;
         buffered_mode_config            <= 1'b0;
         vector_base                     <= 5'b00000;
         cascade_device_config           <= 8'h00;
      end else begin
         state                           <= state_next;
         pulse                           <= pulse_next;
         write_data                      <= write_data_next;
         level_or_edge_toriggered_config <= level_next;
         single_or_cascade_config        <= single_next;
         set_icw4_config                 <= set_icw4_next;
         mode                            <= mode_next;
         auto_eoi_config                 <= aeoi_next;
         buffered_master_or_slave_config <= ms_next;
         buffered_mode_config            <= buf_next;
         vector_base                     <= vector_next;
         cascade_device_config           <= cascade_next;
      end
   end

endmodule

// File: tb/tb_init_command_sequencer.sv
// Self-checking bench for init_command_sequencer: directed scenarios plus
// randomized writes, compared against a behavioural model of the sequence.
module tb_init_command_sequencer;

   logic       clk;
   logic       reset_n;
   logic       chip_select_n;
   logic       write_enable_n;
   logic       address;
   logic [7:0] internal_data_bus;
   logic       ICW_1, ICW_2_4, OCW_1, OCW_2, OCW_3;
   logic [7:0] write_data;
   logic       level_cfg, single_cfg, icw4_cfg, mode, aeoi_cfg, ms_cfg, buf_cfg;
   logic [4:0] vector_base;
   logic [7:0] cascade_device_config;
   logic       init_done;

   int compared   = 0;
   int mismatched = 0;

   init_command_sequencer dut (
      .clk                             (clk),
      .reset_n                         (reset_n),
      .chip_select_n                   (chip_select_n),
      .write_enable_n                  (write_enable_n),
      .address                         (address),
      .internal_data_bus               (internal_data_bus),
      .ICW_1                           (ICW_1),
      .ICW_2_4                         (ICW_2_4),
      .OCW_1                           (OCW_1),
      .OCW_2                           (OCW_2),
      .OCW_3                           (OCW_3),
      .write_data                      (write_data),
      .level_or_edge_toriggered_config (level_cfg),
      .single_or_cascade_config        (single_cfg),
      .set_icw4_config                 (icw4_cfg),
      .mode                            (mode),
      .auto_eoi_config                 (aeoi_cfg),
      .buffered_master_or_slave_config (ms_cfg),
      .buffered_mode_config            (buf_cfg),
      .vector_base                     (vector_base),
      .cascade_device_config           (cascade_device_config),
      .init_done                       (init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse vector order: ICW_1, ICW_2_4, OCW_1, OCW_2, OCW_3
   logic [4:0]  pulses;
   logic [20:0] cfg;
   assign pulses = {ICW_1, ICW_2_4, OCW_1, OCW_2, OCW_3};
   assign cfg    = {level_cfg, single_cfg, icw4_cfg, mode, aeoi_cfg, ms_cfg, buf_cfg,
                    vector_base, cascade_device_config, init_done};

   localparam logic [4:0] P_NONE  = 5'b00000;
   localparam logic [4:0] P_ICW1  = 5'b10000;
   localparam logic [4:0] P_ICW24 = 5'b01000;
   localparam logic [4:0] P_OCW1  = 5'b00100;
   localparam logic [4:0] P_OCW2  = 5'b00010;
   localparam logic [4:0] P_OCW3  = 5'b00001;

   // Reference model: "expect" = which command word the device wants next
   // (1..4 = ICW number, 5 = initialised), plus the programmed fields.
   int         m_expect;
   logic       m_ltim, m_sngl, m_ic4, m_upm, m_aeoi, m_ms, m_buf;
   logic [4:0] m_vector;
   logic [7:0] m_cascade;

   task automatic model_reset();
      m_expect = 1;
      {m_ltim, m_sngl, m_ic4, m_upm, m_aeoi, m_ms, m_buf} = 7'b0;
      m_vector  = 5'd0;
      m_cascade = 8'd0;
   endtask

   function automatic logic [20:0] model_cfg();
      return {m_ltim, m_sngl, m_ic4, m_upm, m_aeoi, m_ms, m_buf,
              m_vector, m_cascade, (m_expect == 5)};
   endfunction

   // Apply one completed CPU write to the model and return the expected pulse
   function automatic logic [4:0] model_write(input logic a, input logic [7:0] d);
      logic [4:0] p;
      p = P_NONE;
      if (!a && d[4]) begin
         p = P_ICW1;
         m_ltim = d[3]; m_sngl = d[1]; m_ic4 = d[0];
         m_cascade = 8'd0;
         {m_upm, m_aeoi, m_ms, m_buf} = 4'b0;
         m_expect = 2;
      end else if (a) begin
         if (m_expect == 2) begin
            p = P_ICW24;
            m_vector = d >> 3;
            if (!m_sngl)     m_expect = 3;
            else if (m_ic4)  m_expect = 4;
            else             m_expect = 5;
         end else if (m_expect == 3) begin
            p = P_ICW24;
            m_cascade = d;
            m_expect  = m_ic4 ? 4 : 5;
         end else if (m_expect == 4) begin
            p = P_ICW24;
            m_upm = d[0]; m_aeoi = d[1]; m_ms = d[2]; m_buf = d[3];
            m_expect = 5;
         end else if (m_expect == 5) begin
            p = P_OCW1;
         end
      end else if (m_expect == 5) begin
         p = d[3] ? P_OCW3 : P_OCW2;
      end
      return p;
   endfunction

   // Drive one write with a strobe of len cycles and record what the DUT shows:
   // any pulse during the strobe or event cycle, the cycle after, and the one after that.
   task automatic do_write(input logic a, input logic [7:0] d, input int len,
                           output logic [4:0] early, output logic [4:0] pulse,
                           output logic [4:0] late, output logic [7:0] wdata,
                           output logic [20:0] cfg_now);
      early = P_NONE;
      @(posedge clk); #1;
      chip_select_n = 1'b0; write_enable_n = 1'b0; address = a; internal_data_bus = d;
      repeat (len) begin
         @(posedge clk); #1;
         early |= pulses;
      end
      chip_select_n = 1'b1; write_enable_n = 1'b1;
      address = 1'($urandom); internal_data_bus = 8'($urandom);
      early |= pulses;
      @(posedge clk); #1;
      pulse = pulses; wdata = write_data; cfg_now = cfg;
      @(posedge clk); #1;
      late = pulses;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      chip_select_n = 1'b1; write_enable_n = 1'b1; address = 1'b0; internal_data_bus = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_reset();
      compared++; if (pulses !== P_NONE) begin mismatched++; $display("[TB] FAIL reset_pulses: got %b expected %b", pulses, P_NONE); end
      compared++; if (write_data !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_write_data: got %h expected 00", write_data); end
      compared++; if (cfg !== 21'd0) begin mismatched++; $display("[TB] FAIL reset_cfg: got %h expected %h", cfg, 21'd0); end
   endtask

   task automatic test_single_icw4();
      logic       sa[3] = '{1'b0, 1'b1, 1'b1};
      logic [7:0] sd[3] = '{8'h13, 8'h48, 8'h03};
      logic [4:0] exp, early, pulse, late;
      logic [7:0] wd;
      logic [20:0] cf;
      int icw24 = 0;
      for (int i = 0; i < 3; i++) begin
         exp = model_write(sa[i], sd[i]);
         do_write(sa[i], sd[i], 1, early, pulse, late, wd, cf);
         if (pulse == P_ICW24) icw24++;
         compared++; if (early !== P_NONE) begin mismatched++; $display("[TB] FAIL single_early%0d: got %b expected %b", i, early, P_NONE); end
         compared++; if (pulse !== exp) begin mismatched++; $display("[TB] FAIL single_pulse%0d: got %b expected %b", i, pulse, exp); end
         compared++; if (late !== P_NONE) begin mismatched++; $display("[TB] FAIL single_late%0d: got %b expected %b", i, late, P_NONE); end
         compared++; if (wd !== sd[i]) begin mismatched++; $display("[TB] FAIL single_wdata%0d: got %h expected %h", i, wd, sd[i]); end
         compared++; if (cf !== model_cfg()) begin mismatched++; $display("[TB] FAIL single_cfg%0d: got %h expected %h", i, cf, model_cfg()); end
      end
      compared++; if (vector_base !== 5'b01001) begin mismatched++; $display("[TB] FAIL single_vector: got %b expected 01001", vector_base); end
      compared++; if ({mode, aeoi_cfg, init_done} !== 3'b111) begin mismatched++; $display("[TB] FAIL single_mode_aeoi_done: got %b expected 111", {mode, aeoi_cfg, init_done}); end
      compared++; if (icw24 !== 2) begin mismatched++; $display("[TB] FAIL single_icw24_count: got %0d expected 2", icw24); end
   endtask

   task automatic test_cascade();
      logic       sa[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      logic [7:0] sd[4] = '{8'h11, 8'h20, 8'h04, 8'h0D};
      logic [4:0] exp, early, pulse, late;
      logic [7:0] wd;
      logic [20:0] cf;
      int icw24 = 0;
      for (int i = 0; i < 4; i++) begin
         exp = model_write(sa[i], sd[i]);
         do_write(sa[i], sd[i], 2, early, pulse, late, wd, cf);
         if (pulse == P_ICW24) icw24++;
         compared++; if (early !== P_NONE) begin mismatched++; $display("[TB] FAIL cascade_early%0d: got %b expected %b", i, early, P_NONE); end
         compared++; if (pulse !== exp) begin mismatched++; $display("[TB] FAIL cascade_pulse%0d: got %b expected %b", i, pulse, exp); end
         compared++; if (late !== P_NONE) begin mismatched++; $display("[TB] FAIL cascade_late%0d: got %b expected %b", i, late, P_NONE); end
         compared++; if (cf !== model_cfg()) begin mismatched++; $display("[TB] FAIL cascade_cfg%0d: got %h expected %h", i, cf, model_cfg()); end
      end
      compared++; if (icw24 !== 3) begin mismatched++; $display("[TB] FAIL cascade_icw24_count: got %0d expected 3", icw24); end
      compared++; if (cascade_device_config !== 8'h04) begin mismatched++; $display("[TB] FAIL cascade_device: got %h expected 04", cascade_device_config); end
      compared++; if ({buf_cfg, ms_cfg, init_done} !== 3'b111) begin mismatched++; $display("[TB] FAIL cascade_buf_ms_done: got %b expected 111", {buf_cfg, ms_cfg, init_done}); end
   endtask

   task automatic test_ocw();
      logic       sa[3] = '{1'b1, 1'b0, 1'b0};
      logic [7:0] sd[3] = '{8'hFB, 8'h20, 8'h0B};
      logic [4:0] want[3] = '{P_OCW1, P_OCW2, P_OCW3};
      logic [4:0] exp, early, pulse, late;
      logic [7:0] wd;
      logic [20:0] cf;
      for (int i = 0; i < 3; i++) begin
         exp = model_write(sa[i], sd[i]);
         do_write(sa[i], sd[i], 1, early, pulse, late, wd, cf);
         compared++; if (pulse !== want[i] || pulse !== exp) begin mismatched++; $display("[TB] FAIL ocw_pulse%0d: got %b expected %b", i, pulse, want[i]); end
         compared++; if (wd !== sd[i]) begin mismatched++; $display("[TB] FAIL ocw_wdata%0d: got %h expected %h", i, wd, sd[i]); end
         compared++; if ((early | late) !== P_NONE) begin mismatched++; $display("[TB] FAIL ocw_extra%0d: got %b expected %b", i, early | late, P_NONE); end
         compared++; if (cf !== model_cfg()) begin mismatched++; $display("[TB] FAIL ocw_cfg%0d: got %h expected %h", i, cf, model_cfg()); end
      end
   endtask

   task automatic test_long_strobe();
      logic [4:0] exp, early, pulse, late;
      logic [7:0] wd;
      logic [20:0] cf;
      exp = model_write(1'b0, 8'h13);
      do_write(1'b0, 8'h13, 5, early, pulse, late, wd, cf);
      compared++; if (early !== P_NONE) begin mismatched++; $display("[TB] FAIL long_early: got %b expected %b", early, P_NONE); end
      compared++; if (pulse !== P_ICW1 || pulse !== exp) begin mismatched++; $display("[TB] FAIL long_pulse: got %b expected %b", pulse, P_ICW1); end
      compared++; if (late !== P_NONE) begin mismatched++; $display("[TB] FAIL long_late: got %b expected %b", late, P_NONE); end
      compared++; if (cf !== model_cfg()) begin mismatched++; $display("[TB] FAIL long_cfg: got %h expected %h", cf, model_cfg()); end
   endtask

   task automatic test_restart();
      logic       sa[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [7:0] sd[9] = '{8'h20, 8'h13, 8'h48, 8'h0F, 8'h13, 8'h48, 8'h1B, 8'h08, 8'h01};
      logic [4:0] exp, early, pulse, late;
      logic [7:0] wd;
      logic [20:0] cf;
      test_reset();
      for (int i = 0; i < 9; i++) begin
         exp = model_write(sa[i], sd[i]);
         do_write(sa[i], sd[i], 1, early, pulse, late, wd, cf);
         compared++; if (pulse !== exp) begin mismatched++; $display("[TB] FAIL restart_pulse%0d: got %b expected %b", i, pulse, exp); end
         compared++; if ((early | late) !== P_NONE) begin mismatched++; $display("[TB] FAIL restart_extra%0d: got %b expected %b", i, early | late, P_NONE); end
         compared++; if (cf !== model_cfg()) begin mismatched++; $display("[TB] FAIL restart_cfg%0d: got %h expected %h", i, cf, model_cfg()); end
         if (i == 0) begin
            compared++; if (pulse !== P_NONE) begin mismatched++; $display("[TB] FAIL restart_ocw_ignored: got %b expected %b", pulse, P_NONE); end
         end
         if (i == 6) begin
            compared++; if ({mode, aeoi_cfg, ms_cfg, buf_cfg, level_cfg} !== 5'b00001) begin mismatched++; $display("[TB] FAIL restart_icw4_cleared: got %b expected 00001", {mode, aeoi_cfg, ms_cfg, buf_cfg, level_cfg}); end
         end
      end
   endtask

   task automatic test_reset_mid_strobe();
      logic [4:0] exp, early, pulse, late, seen;
      logic [7:0] wd;
      logic [20:0] cf;
      exp = model_write(1'b0, 8'h13);
      do_write(1'b0, 8'h13, 1, early, pulse, late, wd, cf);
      @(posedge clk); #1;
      chip_select_n = 1'b0; write_enable_n = 1'b0; address = 1'b0; internal_data_bus = 8'h13;
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      model_reset();
      seen = P_NONE;
      repeat (2) begin @(posedge clk); #1; seen |= pulses; end
      chip_select_n = 1'b1; write_enable_n = 1'b1;
      repeat (4) begin @(posedge clk); #1; seen |= pulses; end
      compared++; if (seen !== P_NONE) begin mismatched++; $display("[TB] FAIL midreset_pulse: got %b expected %b", seen, P_NONE); end
      compared++; if (cfg !== model_cfg()) begin mismatched++; $display("[TB] FAIL midreset_cfg: got %h expected %h", cfg, model_cfg()); end
      compared++; if (write_data !== 8'h00) begin mismatched++; $display("[TB] FAIL midreset_wdata: got %h expected 00", write_data); end
      exp = model_write(1'b1, 8'hFF);
      do_write(1'b1, 8'hFF, 1, early, pulse, late, wd, cf);
      compared++; if ((early | pulse | late) !== exp) begin mismatched++; $display("[TB] FAIL midreset_wait_icw1: got %b expected %b", early | pulse | late, exp); end
   endtask

   task automatic test_random();
      logic       a;
      logic [7:0] d;
      int         len;
      logic [4:0] exp, early, pulse, late;
      logic [7:0] wd;
      logic [20:0] cf;
      for (int i = 0; i < 150; i++) begin
         a   = ($urandom_range(0, 9) < 7);
         d   = 8'($urandom);
         len = $urandom_range(1, 3);
         exp = model_write(a, d);
         do_write(a, d, len, early, pulse, late, wd, cf);
         compared++; if (pulse !== exp) begin mismatched++; $display("[TB] FAIL rand_pulse%0d: a=%b d=%h got %b expected %b", i, a, d, pulse, exp); end
         compared++; if ((early | late) !== P_NONE) begin mismatched++; $display("[TB] FAIL rand_extra%0d: got %b expected %b", i, early | late, P_NONE); end
         compared++; if (cf !== model_cfg()) begin mismatched++; $display("[TB] FAIL rand_cfg%0d: got %h expected %h", i, cf, model_cfg()); end
         if (exp != P_NONE) begin
            compared++; if (wd !== d) begin mismatched++; $display("[TB] FAIL rand_wdata%0d: got %h expected %h", i, wd, d); end
         end
      end
   endtask

   // Run every scenario in order, then report
   initial begin
      test_reset();
      test_single_icw4();
      test_ocw();
      test_cascade();
      test_long_strobe();
      test_restart();
      test_reset_mid_strobe();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
